writeback_arbiter: RTL

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/riscv_pkg.sv | 16 +
 rtl/writeback_arbiter_if.sv | 37 +++
 rtl/wb_fifo.sv | 49 ++++
 rtl/writeback_arbiter.sv | 111 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core types for the writeback path: data/register widths, the buffered
// writeback entry, and the two writeback sources.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;
endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundle of the ALU/MEM result handshakes, register-file write port and the
// decode-side bypass read ports around the writeback arbiter.
interface writeback_arbiter_if;
  import riscv_pkg::*;

  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  wb_write_en;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic [XLEN-1:0]       wb_rd_data;
  logic [REG_ADDR_W-1:0] byp_rs1_addr;
  logic [REG_ADDR_W-1:0] byp_rs2_addr;
  logic                  byp_rs1_hit;
  logic                  byp_rs2_hit;
  logic [XLEN-1:0]       byp_rs1_data;
  logic [XLEN-1:0]       byp_rs2_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           byp_rs1_addr, byp_rs2_addr,
    input  alu_ready, mem_ready, wb_write_en, wb_rd_addr, wb_rd_data,
           byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           byp_rs1_addr, byp_rs2_addr,
    output alu_ready, mem_ready, wb_write_en, wb_rd_addr, wb_rd_data,
           byp_rs1_hit, byp_rs2_hit, byp_rs1_data, byp_rs2_data
  );
endinterface

// File: rtl/wb_fifo.sv
// In-order buffer of pending writeback entries for one source; head is visible
// combinationally so the arbiter can pop and register it on the same edge.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  // Push is gated on the registered full flag, so a pop on the same edge never frees a slot early.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = storage[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) storage[wr_ptr_reg] <= push_entry;
  end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into the single register-file write port with
// round-robin arbitration, and forwards the in-flight write to decode.
module writeback_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = riscv_pkg::XLEN
) (
  input logic              clk,
  input logic              rst_n,
  writeback_arbiter_if.slave bus
);
  logic [1:0]            src_valid;
  logic [1:0]            src_push;
  logic [1:0]            src_pop;
  logic [1:0]            src_full;
  logic [1:0]            src_empty;
  wb_entry_t             src_entry [2];
  wb_entry_t             src_head  [2];
  wb_entry_t             pop_entry;

  wb_src_e               last_grant_reg;
  wb_src_e               last_grant_next;
  logic                  wb_write_en_reg;
  logic [REG_ADDR_W-1:0] wb_rd_addr_reg;
  logic [XLEN-1:0]       wb_rd_data_reg;

  logic [REG_ADDR_W-1:0] byp_addr [2];
  logic [1:0]            byp_hit;
  logic [XLEN-1:0]       byp_data [2];

  assign src_valid    = {bus.mem_valid, bus.alu_valid};
  assign src_entry[0] = '{rd: bus.alu_rd, data: bus.alu_data};
  assign src_entry[1] = '{rd: bus.mem_rd, data: bus.mem_data};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_push[gi] = rst_n && src_valid[gi] && !src_full[gi];
      wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (src_push[gi]),
        .push_entry (src_entry[gi]),
        .pop        (src_pop[gi]),
        .full       (src_full[gi]),
        .empty      (src_empty[gi]),
        .head       (src_head[gi])
      );
    end
  endgenerate

  // Ready is held low through reset even though the buffers may still look non-full.
  assign bus.alu_ready = rst_n && !src_full[0];
  assign bus.mem_ready = rst_n && !src_full[1];

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_reg <= WB_SRC_MEM;
    else        last_grant_reg <= last_grant_next;
  end

  always_comb begin
    src_pop         = '0;
    last_grant_next = last_grant_reg;
    pop_entry       = src_head[0];
    if (!src_empty[0] && (src_empty[1] || last_grant_reg == WB_SRC_MEM)) begin
      src_pop[0]      = 1'b1;
      last_grant_next = WB_SRC_ALU;
      pop_entry       = src_head[0];
    end else if (!src_empty[1]) begin
      src_pop[1]      = 1'b1;
      last_grant_next = WB_SRC_MEM;
      pop_entry       = src_head[1];
    end
  end

  // x0 entries are consumed like any other but never strobe the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_write_en_reg <= 1'b0;
      wb_rd_addr_reg  <= '0;
      wb_rd_data_reg  <= '0;
    end else if (|src_pop) begin
      wb_write_en_reg <= (pop_entry.rd != '0);
      wb_rd_addr_reg  <= pop_entry.rd;
      wb_rd_data_reg  <= XLEN'(pop_entry.data);
    end else begin
      wb_write_en_reg <= 1'b0;
    end
  end

  assign bus.wb_write_en = wb_write_en_reg;
  assign bus.wb_rd_addr  = wb_rd_addr_reg;
  assign bus.wb_rd_data  = wb_rd_data_reg;

  assign byp_addr[0] = bus.byp_rs1_addr;
  assign byp_addr[1] = bus.byp_rs2_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_byp
      assign byp_hit[gi]  = rst_n && wb_write_en_reg && (wb_rd_addr_reg == byp_addr[gi])
                            && (byp_addr[gi] != '0);
      assign byp_data[gi] = byp_hit[gi] ? wb_rd_data_reg : '0;
    end
  endgenerate

  assign bus.byp_rs1_hit  = byp_hit[0];
  assign bus.byp_rs2_hit  = byp_hit[1];
  assign bus.byp_rs1_data = byp_data[0];
  assign bus.byp_rs2_data = byp_data[1];
endmodule
